// File: rtl/adc_sample_packer_if.sv
// Handshake bundle between the capture FIFO / USB read mux side and the ADC sample packer.
// The master modport is the environment; the slave modport is the packer itself.
interface adc_sample_packer_if #(
  parameter int unsigned pCOUNT_WIDTH = 32
);
  logic                    low_res;
  logic                    clear;
  logic [11:0]             in_sample;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic                    flush_done;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [pCOUNT_WIDTH-1:0] byte_count;

  modport master (
    output low_res,
    output clear,
    output in_sample,
    output in_valid,
    output flush,
    output out_ready,
    input  in_ready,
    input  flush_done,
    input  out_data,
    input  out_valid,
    input  byte_count
  );

  modport slave (
    input  low_res,
    input  clear,
    input  in_sample,
    input  in_valid,
    input  flush,
    input  out_ready,
    output in_ready,
    output flush_done,
    output out_data,
    output out_valid,
    output byte_count
  );
endinterface

// File: rtl/adc_sample_packer.sv
// Packs 12-bit ADC samples into bytes: two samples -> three bytes (12-bit mode) or one byte
// per sample (low-resolution mode), through a 2-entry byte queue with flush and byte count.
module adc_sample_packer #(
  parameter int unsigned pCOUNT_WIDTH = 32,
  parameter int unsigned pQUEUE_DEPTH = 2
) (
  input logic               clk_usb,
  input logic               reset,
  adc_sample_packer_if.slave bus_io
);

  if (pQUEUE_DEPTH != 2) begin : g_bad_depth
    $error("adc_sample_packer: pQUEUE_DEPTH must be 2");
  end

  typedef enum logic [0:0] {
    StP0,
    StP1
  } phase_e;

  phase_e                  state_q, state_d;
  logic [3:0]              nib_q, nib_d;
  logic                    mode_q, mode_d;
  logic                    mode_eff;
  logic [7:0]              ent0_q, ent0_d;
  logic [7:0]              ent1_q, ent1_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    flush_done_q, flush_done_d;
  logic [pCOUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic                    in_ready;
  logic                    accept;
  logic                    pop;
  logic [1:0]              push_n;
  logic [7:0]              push_b0;
  logic [7:0]              push_b1;

  // The mode only latches at a clean byte boundary: no nibble held and nothing queued.
  always_comb begin
    mode_eff = mode_q;
    if (state_q == StP0 && cnt_q == 2'd0) begin
      mode_eff = bus_io.low_res;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (bus_io.clear || flush_pend_q) begin
      in_ready = 1'b0;
    end else if (mode_eff || state_q == StP0) begin
      in_ready = (cnt_q < 2'd2);
    end else begin
      // A P1 sample pushes two bytes, so it needs both slots after this cycle's pop.
      in_ready = (cnt_q == 2'd0) || (cnt_q == 2'd1 && bus_io.out_ready);
    end
  end

  assign accept = bus_io.in_valid && in_ready;
  assign pop    = valid_q && bus_io.out_ready;

  // Decide what (if anything) enters the queue this cycle and advance the phase.
  always_comb begin
    push_n       = 2'd0;
    push_b0      = 8'h00;
    push_b1      = 8'h00;
    state_d      = state_q;
    nib_d        = nib_q;
    mode_d       = mode_eff;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;

    if (accept) begin
      if (mode_eff) begin
        push_n  = 2'd1;
        push_b0 = bus_io.in_sample[11:4];
      end else if (state_q == StP0) begin
        push_n  = 2'd1;
        push_b0 = bus_io.in_sample[11:4];
        nib_d   = bus_io.in_sample[3:0];
        state_d = StP1;
      end else begin
        push_n  = 2'd2;
        push_b0 = {nib_q, bus_io.in_sample[11:8]};
        push_b1 = bus_io.in_sample[7:0];
        state_d = StP0;
      end
    end else if (flush_pend_q && cnt_q != 2'd2) begin
      push_n       = 2'd1;
      push_b0      = {nib_q, 4'h0};
      state_d      = StP0;
      flush_pend_d = 1'b0;
      flush_done_d = 1'b1;
    end

    // Judge the flush against the phase this cycle leaves behind.
    if (bus_io.flush && !flush_pend_q) begin
      if (state_d == StP1) begin
        flush_pend_d = 1'b1;
      end else begin
        flush_done_d = 1'b1;
      end
    end
  end

  // Two-entry byte queue: pop shifts entry 1 to the head, pushes append behind what remains.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;

    if (pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end

    if (push_n != 2'd0) begin
      if (cnt_d == 2'd0) begin
        ent0_d = push_b0;
      end else begin
        ent1_d = push_b0;
      end
      cnt_d = cnt_d + 2'd1;
    end

    if (push_n == 2'd2) begin
      ent1_d = push_b1;
      cnt_d  = cnt_d + 2'd1;
    end

    valid_d    = (cnt_d != 2'd0);
    byte_cnt_d = byte_cnt_q + pCOUNT_WIDTH'(pop);
  end

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state_q      <= StP0;
      nib_q        <= 4'h0;
      mode_q       <= 1'b0;
      ent0_q       <= 8'h00;
      ent1_q       <= 8'h00;
      cnt_q        <= 2'd0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else if (bus_io.clear) begin
      state_q      <= StP0;
      nib_q        <= 4'h0;
      mode_q       <= mode_d;
      ent0_q       <= 8'h00;
      ent1_q       <= 8'h00;
      cnt_q        <= 2'd0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      mode_q       <= mode_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.out_data   = ent0_q;
  assign bus_io.out_valid  = valid_q;
  assign bus_io.flush_done = flush_done_q;
  assign bus_io.byte_count = byte_cnt_q;

`ifndef SYNTHESIS
  a_cnt_max : assert property (@(posedge clk_usb) disable iff (reset) cnt_q <= 2'd2);

  a_valid_tracks_cnt : assert property (@(posedge clk_usb) disable iff (reset)
    valid_q == (cnt_q != 2'd0));

  a_head_stable : assert property (@(posedge clk_usb) disable iff (reset)
    (valid_q && !bus_io.out_ready && !bus_io.clear) |=> $stable(ent0_q));
`endif

endmodule

// File: tb/tb_adc_sample_packer.sv
// Self-checking bench for adc_sample_packer: directed scenarios plus randomized traffic,
// with a nibble-stream reference model scoring every consumed byte.
module tb_adc_sample_packer;

  logic clk_usb = 1'b0;
  logic reset;

  always #5 clk_usb = ~clk_usb;

  adc_sample_packer_if #(.pCOUNT_WIDTH(32)) bus ();

  adc_sample_packer #(
    .pCOUNT_WIDTH(32),
    .pQUEUE_DEPTH(2)
  ) dut (
    .clk_usb(clk_usb),
    .reset  (reset),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 12-bit samples become a nibble stream read two nibbles per byte.
  logic [7:0] exp_q[$];
  logic [3:0] nib_q[$];
  int         model_count;

  function automatic void model_reset();
    exp_q.delete();
    nib_q.delete();
    model_count = 0;
  endfunction

  function automatic void model_accept(input logic [11:0] s, input logic lr);
    if (lr) begin
      exp_q.push_back(s[11:4]);
    end else begin
      nib_q.push_back(s[11:8]);
      nib_q.push_back(s[7:4]);
      nib_q.push_back(s[3:0]);
      while (nib_q.size() >= 2) begin
        exp_q.push_back({nib_q[0], nib_q[1]});
        void'(nib_q.pop_front());
        void'(nib_q.pop_front());
      end
    end
  endfunction

  function automatic void model_flush();
    if (nib_q.size() == 1) begin
      exp_q.push_back({nib_q[0], 4'h0});
      nib_q.delete();
    end
  endfunction

  // Scoreboard: handshakes are judged mid-cycle, when inputs and outputs are settled.
  always @(negedge clk_usb) begin
    if (!reset && !bus.clear) begin
      if (bus.in_valid && bus.in_ready) model_accept(bus.in_sample, bus.low_res);
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got byte %02h, want no byte", bus.out_data);
        end else begin
          if (bus.out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL scoreboard_order: got %02h, want %02h", bus.out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        model_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic send(input logic [11:0] s);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk_usb);
      acc = (bus.in_ready === 1'b1);
      tick();
      t++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: sample %03h not accepted, want accepted within 100", s);
    end
  endtask

  task automatic clear_pulse();
    bus.clear = 1'b1;
    model_reset();
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk_usb);
      done = (bus.out_valid === 1'b0) && (exp_q.size() == 0);
      tick();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes still expected, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_out_data: got %02h want 00", bus.out_data);
    end
    n_checks++;
    if (bus.flush_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flush_done: got %b want 0", bus.flush_done);
    end
    n_checks++;
    if (bus.byte_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_byte_count: got %0d want 0", bus.byte_count);
    end
    repeat (2) @(posedge clk_usb);
    @(negedge clk_usb);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stream();
    bus.low_res   = 1'b0;
    bus.out_ready = 1'b0;
    send(12'h123);
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12) begin
      n_fail++;
      $display("FAIL midreset_pre: got v=%b d=%02h want v=1 d=12", bus.out_valid, bus.out_data);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.byte_count !== 32'd0) begin
      n_fail++; $display("FAIL midreset_byte_count: got %0d want 0", bus.byte_count);
    end
    @(posedge clk_usb);
    @(negedge clk_usb);
    reset = 1'b0;
    tick();
    send(12'h456);
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h45) begin
      n_fail++;
      $display("FAIL midreset_first_byte: got v=%b d=%02h want v=1 d=45",
               bus.out_valid, bus.out_data);
    end
    tick();
    bus.flush = 1'b1;
    model_flush();
    tick();
    bus.flush = 1'b0;
    drain();
  endtask

  task automatic test_pack12();
    bus.low_res   = 1'b0;
    bus.out_ready = 1'b1;
    clear_pulse();
    bus.in_sample = 12'h123;
    bus.in_valid  = 1'b1;
    @(negedge clk_usb);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pack12_accept_a: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_sample = 12'h456;
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12) begin
      n_fail++; $display("FAIL pack12_byte0: got v=%b d=%02h want v=1 d=12",
                         bus.out_valid, bus.out_data);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pack12_accept_b: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h34) begin
      n_fail++; $display("FAIL pack12_byte1: got v=%b d=%02h want v=1 d=34",
                         bus.out_valid, bus.out_data);
    end
    tick();
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h56) begin
      n_fail++; $display("FAIL pack12_byte2: got v=%b d=%02h want v=1 d=56",
                         bus.out_valid, bus.out_data);
    end
    tick();
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL pack12_empty: got out_valid=%b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.byte_count !== 32'd3) begin
      n_fail++; $display("FAIL pack12_count: got %0d want 3", bus.byte_count);
    end
    tick();
  endtask

  task automatic test_ramp8();
    bus.low_res   = 1'b1;
    bus.out_ready = 1'b1;
    clear_pulse();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_sample = 12'(i * 16);
      @(negedge clk_usb);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL ramp8_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      if (i > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i - 1)) begin
          n_fail++; $display("FAIL ramp8_byte[%0d]: got v=%b d=%02h want v=1 d=%02h",
                             i - 1, bus.out_valid, bus.out_data, 8'(i - 1));
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin
      n_fail++; $display("FAIL ramp8_last: got v=%b d=%02h want v=1 d=ff",
                         bus.out_valid, bus.out_data);
    end
    tick();
    @(negedge clk_usb);
    n_checks++;
    if (bus.byte_count !== 32'd256 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ramp8_count: got count=%0d v=%b want count=256 v=0",
                         bus.byte_count, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.low_res   = 1'b0;
    bus.out_ready = 1'b0;
    clear_pulse();
    send(12'hABC);
    bus.in_sample = 12'hDEF;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_usb);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall_in_ready[%0d]: got %b want 0", k, bus.in_ready);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAB) begin
        n_fail++; $display("FAIL bp_stall_head[%0d]: got v=%b d=%02h want v=1 d=ab",
                           k, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk_usb);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hCD) begin
      n_fail++; $display("FAIL bp_byte1: got v=%b d=%02h want v=1 d=cd",
                         bus.out_valid, bus.out_data);
    end
    tick();
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hEF) begin
      n_fail++; $display("FAIL bp_byte2: got v=%b d=%02h want v=1 d=ef",
                         bus.out_valid, bus.out_data);
    end
    tick();
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.byte_count !== 32'd3) begin
      n_fail++; $display("FAIL bp_done: got v=%b count=%0d want v=0 count=3",
                         bus.out_valid, bus.byte_count);
    end
    tick();
  endtask

  task automatic test_flush();
    int   pulses;
    logic prev_in_ready;
    bus.low_res   = 1'b0;
    bus.out_ready = 1'b1;
    clear_pulse();
    send(12'h9A5);
    bus.flush = 1'b1;
    model_flush();
    pulses        = 0;
    prev_in_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_usb);
      if (bus.flush_done === 1'b1) begin
        pulses++;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h50) begin
          n_fail++; $display("FAIL flush_pad_byte: got v=%b d=%02h want v=1 d=50",
                             bus.out_valid, bus.out_data);
        end
        n_checks++;
        if (prev_in_ready !== 1'b0) begin
          n_fail++; $display("FAIL flush_push_in_ready: got %b want 0", prev_in_ready);
        end
      end
      prev_in_ready = bus.in_ready;
      tick();
      bus.flush = 1'b0;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL flush_odd_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (bus.byte_count !== 32'd2) begin
      n_fail++; $display("FAIL flush_odd_count: got %0d want 2", bus.byte_count);
    end
    // Flush with nothing held: done on the next cycle, no byte.
    bus.flush = 1'b1;
    @(negedge clk_usb);
    tick();
    bus.flush = 1'b0;
    @(negedge clk_usb);
    n_checks++;
    if (bus.flush_done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_p0: got done=%b v=%b want done=1 v=0",
                         bus.flush_done, bus.out_valid);
    end
    tick();
    @(negedge clk_usb);
    n_checks++;
    if (bus.flush_done !== 1'b0) begin
      n_fail++; $display("FAIL flush_p0_single: got done=%b want 0", bus.flush_done);
    end
    tick();
    // A second flush while the first is pending is ignored.
    bus.out_ready = 1'b0;
    send(12'h777);
    bus.flush = 1'b1;
    model_flush();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_usb);
      if (bus.flush_done === 1'b1) pulses++;
      tick();
      if (k == 1) bus.flush = 1'b0;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL flush_repeat_pulses: got %0d want 1", pulses);
    end
    drain();
    n_checks++;
    if (bus.byte_count !== 32'(model_count)) begin
      n_fail++; $display("FAIL flush_repeat_count: got %0d want %0d", bus.byte_count,
                         model_count);
    end
  endtask

  task automatic test_same_cycle();
    int pulses;
    bus.low_res   = 1'b0;
    bus.out_ready = 1'b0;
    clear_pulse();
    send(12'h111);
    bus.in_sample = 12'h222;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk_usb);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_p1_pop_accept: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL same_count2: got v=%b d=%02h rdy=%b want v=1 d=12 rdy=0",
                         bus.out_valid, bus.out_data, bus.in_ready);
    end
    tick();
    bus.in_sample = 12'h333;
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    bus.clear     = 1'b1;
    model_reset();
    @(negedge clk_usb);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.clear    = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    pulses = 0;
    @(negedge clk_usb);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.byte_count !== 32'd0) begin
      n_fail++; $display("FAIL clear_empty: got v=%b count=%0d want v=0 count=0",
                         bus.out_valid, bus.byte_count);
    end
    for (int k = 0; k < 5; k++) begin
      if (bus.flush_done === 1'b1) pulses++;
      tick();
      @(negedge clk_usb);
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL clear_flush_dropped: got %0d pulses want 0", pulses);
    end
    tick();
  endtask

  task automatic test_random();
    bit acc;
    bit seen;
    for (int blk = 0; blk < 6; blk++) begin
      bus.low_res = 1'($urandom_range(0, 1));
      acc = 1'b1;
      for (int c = 0; c < 150; c++) begin
        if (!bus.in_valid || acc) begin
          bus.in_valid  = ($urandom_range(0, 3) != 0);
          bus.in_sample = 12'($urandom);
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk_usb);
        acc = bus.in_valid && (bus.in_ready === 1'b1);
        tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      model_flush();
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk_usb);
        seen = (bus.flush_done === 1'b1);
        tick();
        bus.flush = 1'b0;
      end
      n_checks++;
      if (!seen) begin
        n_fail++; $display("FAIL rand_flush_done[%0d]: got no pulse want pulse", blk);
      end
      drain();
      n_checks++;
      if (bus.byte_count !== 32'(model_count)) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", blk, bus.byte_count,
                           model_count);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.low_res   = 1'b0;
    bus.clear     = 1'b0;
    bus.in_sample = 12'h000;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    test_reset();
    test_reset_mid_stream();
    test_pack12();
    test_ramp8();
    test_backpressure();
    test_flush();
    test_same_cycle();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
